// File: rtl/decoder_onehot_seq.sv
// Registered binary-to-one-hot decoder with LATCH, PULSE and SWEEP modes.
// Drives register-file enable selects; dec_out is always one-hot or zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a load; LATCH values are held here
// S_PULSE | one-hot strobe active, cnt counts cycles up to PULSE_LEN
// S_SWEEP | walking the one-hot across all outputs, step counts steps
module decoder_onehot_seq #(
  parameter int IN_W      = 4,
  parameter int PULSE_LEN = 1
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 load,
  input  logic [1:0]           mode,
  input  logic [IN_W-1:0]      dec_in,
  output logic [2**IN_W-1:0]   dec_out,
  output logic                 busy,
  output logic                 done
);

  localparam int OUT_W = 2**IN_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_SWEEP = 2'd2;

  localparam logic [1:0] M_LATCH = 2'd0;
  localparam logic [1:0] M_PULSE = 2'd1;
  localparam logic [1:0] M_SWEEP = 2'd2;

  localparam logic [7:0]    PULSE_LAST = 8'(PULSE_LEN);
  localparam logic [IN_W:0] SWEEP_LAST = (IN_W+1)'(OUT_W);

  logic [1:0]      state;
  logic [7:0]      cnt;
  logic [IN_W:0]   step;
  logic [IN_W-1:0] idx;
  logic [IN_W-1:0] idx_next;
  logic            accept;

  function automatic logic [OUT_W-1:0] onehot(input logic [IN_W-1:0] sel);
    onehot = {{(OUT_W-1){1'b0}}, 1'b1} << sel;
  endfunction

  // A load is taken only when nothing is in progress and the mode is defined.
  assign accept   = load && !busy && (mode != 2'b11);
  assign idx_next = idx + IN_W'(1);

  // Sequencer: accepts loads in IDLE and times out PULSE/SWEEP operations.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= S_IDLE;
      dec_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      step    <= '0;
      idx     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            dec_out <= onehot(dec_in);
            case (mode)
              M_LATCH: done <= 1'b1;
              M_PULSE: begin
                busy  <= 1'b1;
                state <= S_PULSE;
                cnt   <= 8'd1;
              end
              M_SWEEP: begin
                busy  <= 1'b1;
                state <= S_SWEEP;
                step  <= (IN_W+1)'(1);
                idx   <= dec_in;
              end
              default: ;
            endcase
          end
        end
        S_PULSE: begin
          if (cnt == PULSE_LAST) begin
            dec_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            cnt     <= '0;
            state   <= S_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_SWEEP: begin
          if (step == SWEEP_LAST) begin
            dec_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            step    <= '0;
            state   <= S_IDLE;
          end else begin
            // Index is IN_W bits wide, so the walk wraps OUT_W-1 -> 0 on its own.
            idx     <= idx_next;
            dec_out <= onehot(idx_next);
            step    <= step + (IN_W+1)'(1);
          end
        end
        default: begin
          dec_out <= '0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
